// File: rtl/filter_scan_ctrl_if.sv
// Bundle of control, channel and status signals for filter_scan_ctrl.
// master drives the controls and raw inputs; slave (the filter) drives status and filtered levels.
interface filter_scan_ctrl_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 16
);
  logic             enable;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic [N_CH-1:0]  sig_in;
  logic [N_CH-1:0]  sig_out;
  logic             busy;
  logic             round_done;
  logic             overrun;
  logic             irq;
  logic             chg_clr;

  modport master (
    output enable, div_load, div_value, sig_in, chg_clr,
    input  sig_out, busy, round_done, overrun, irq
  );

  modport slave (
    input  enable, div_load, div_value, sig_in, chg_clr,
    output sig_out, busy, round_done, overrun, irq
  );
endinterface

// File: rtl/filter_scan_ctrl.sv
// Shared DEPTH-sample glitch filter, time-multiplexed over N_CH channels on a prescaled tick.
// Optional change interrupt is built when FILTER_CHG_IRQ_EN is defined.
module filter_scan_ctrl #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 3,
  parameter int DIV_W = 16
) (
  input logic          clock,
  input logic          reset,
  filter_scan_ctrl_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [DIV_W-1:0] divisor;
  logic [DIV_W-1:0] count;
  logic [CH_W-1:0]  ch;
  logic [N_CH-1:0]  snap;
  logic [N_CH-1:0]  level;
  logic [DEPTH-1:0] hist [N_CH];
  logic             busy_q;
  logic             done_q;
  logic             ovr_q;
  logic             tick;
  logic             last_ch;
  logic [DEPTH-1:0] shifted;
  logic             new_level;

  // A load cycle never ticks, even if the old count happened to match.
  assign tick    = (count == divisor - DIV_W'(1)) && !bus.div_load;
  assign last_ch = (ch == CH_W'(N_CH - 1));

  always_comb begin
    shifted   = {hist[ch][DEPTH-2:0], snap[ch]};
    new_level = level[ch];
    if (&shifted)
      new_level = 1'b1;
    else if (~|shifted)
      new_level = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      divisor <= DIV_W'(1);
      count   <= '0;
    end else if (bus.div_load) begin
      divisor <= (bus.div_value == '0) ? DIV_W'(1) : bus.div_value;
      count   <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ch     <= '0;
      snap   <= '0;
      level  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++)
        hist[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.div_load)
        ovr_q <= 1'b0;
      else if (tick && state == SCAN)
        ovr_q <= 1'b1;

      case (state)
        IDLE: begin
          if (tick && bus.enable) begin
            snap   <= bus.sig_in;
            ch     <= '0;
            busy_q <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          hist[ch]  <= shifted;
          level[ch] <= new_level;
          if (last_ch) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sig_out    = level;
  assign bus.busy       = busy_q;
  assign bus.round_done = done_q;
  assign bus.overrun    = ovr_q;

`ifdef FILTER_CHG_IRQ_EN
  logic [N_CH-1:0] chg_pend;
  logic [N_CH-1:0] chg_set;
  logic [N_CH-1:0] pend_next;
  logic            irq_q;

  // Set is OR-ed in after the clear so a same-cycle change keeps its bit.
  always_comb begin
    chg_set = '0;
    if (state == SCAN && new_level != level[ch])
      chg_set[ch] = 1'b1;
    pend_next = (chg_pend & ~{N_CH{bus.chg_clr}}) | chg_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chg_pend <= '0;
      irq_q    <= 1'b0;
    end else begin
      chg_pend <= pend_next;
      irq_q    <= |pend_next;
    end
  end

  assign bus.irq = irq_q;
`else
  logic unused_chg_clr;
  assign unused_chg_clr = bus.chg_clr;
  assign bus.irq        = 1'b0;
`endif
endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Bench for filter_scan_ctrl: directed steps plus random traffic against a round-level model
// built from tick arithmetic and a queue of per-round input snapshots.
module tb_filter_scan_ctrl;
  localparam int N_CH  = 4;
  localparam int DEPTH = 3;
  localparam int DIV_W = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  filter_scan_ctrl_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();

  filter_scan_ctrl #(.N_CH(N_CH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: cycle of last load/reset, divisor, start cycle of latest round.
  int              div_m    = 1;
  int              load_cyc = 0;
  int              t_start  = -1000;
  logic [N_CH-1:0] prev_m   = '0;
  logic [N_CH-1:0] cur_m    = '0;
  logic [N_CH-1:0] pend_m   = '0;
  logic            ovr_m    = 1'b0;
  logic [N_CH-1:0] snaps [$];

  // Channel k of the latest round becomes visible in cycle t_start+2+k.
  function automatic logic [N_CH-1:0] vis(int x);
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++)
      v[k] = (x < t_start + 2 + k) ? prev_m[k] : cur_m[k];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] filt(logic [N_CH-1:0] hold_v);
    logic [N_CH-1:0] r;
    int ones;
    int n;
    r = hold_v;
    n = (snaps.size() < DEPTH) ? snaps.size() : DEPTH;
    for (int k = 0; k < N_CH; k++) begin
      ones = 0;
      for (int j = 0; j < n; j++)
        ones += int'(snaps[snaps.size() - 1 - j][k]);
      if (ones == DEPTH)
        r[k] = 1'b1;
      else if (ones == 0)
        r[k] = 1'b0;
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(logic en, logic ld, logic [DIV_W-1:0] dv, logic [N_CH-1:0] sin,
                      logic clr, logic rst);
    logic [N_CH-1:0] v0;
    logic            tk;
    logic            scanning;
    logic            irq_exp;
    reset         = rst;
    bus.enable    = en;
    bus.div_load  = ld;
    bus.div_value = dv;
    bus.sig_in    = sin;
    bus.chg_clr   = clr;
    v0 = vis(cyc);
    if (rst) begin
      div_m    = 1;
      load_cyc = cyc;
      t_start  = -1000;
      prev_m   = '0;
      cur_m    = '0;
      pend_m   = '0;
      ovr_m    = 1'b0;
      snaps.delete();
    end else begin
      scanning = (cyc >= t_start + 1) && (cyc <= t_start + N_CH);
      tk = !ld && (cyc > load_cyc) && ((cyc - load_cyc) % div_m == 0);
      if (ld) begin
        div_m    = (dv == '0) ? 1 : int'(dv);
        load_cyc = cyc;
        ovr_m    = 1'b0;
      end
      if (tk && scanning) begin
        ovr_m = 1'b1;
      end else if (tk && en) begin
        t_start = cyc;
        snaps.push_back(sin);
        prev_m = cur_m;
        cur_m  = filt(cur_m);
      end
      pend_m = (pend_m & ~{N_CH{clr}}) | (vis(cyc + 1) ^ v0);
    end
    @(posedge clock);
    #1;
    cyc++;
`ifdef FILTER_CHG_IRQ_EN
    irq_exp = |pend_m;
`else
    irq_exp = 1'b0;
`endif
    check("busy", 32'(bus.busy), 32'((cyc >= t_start + 1) && (cyc <= t_start + N_CH)));
    check("round_done", 32'(bus.round_done), 32'(cyc == t_start + N_CH + 1));
    check("sig_out", 32'(bus.sig_out), 32'(vis(cyc)));
    check("overrun", 32'(bus.overrun), 32'(ovr_m));
    check("irq", 32'(bus.irq), 32'(irq_exp));
  endtask

  task automatic period(logic en, logic [N_CH-1:0] sin, int n);
    for (int i = 0; i < n; i++)
      step(en, 1'b0, '0, sin, 1'b0, 1'b0);
  endtask

  task automatic rand_run(int n, int en_pct);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 99) < en_pct, 1'b0, '0, N_CH'($urandom),
           $urandom_range(0, 3) == 0, 1'b0);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 50 && bus.busy !== 1'b1; i++)
      step(1'b1, 1'b0, '0, N_CH'($urandom), 1'b0, 1'b0);
    check("wait_busy", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    logic [DIV_W-1:0] dv;

    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("reset_out", 32'(bus.sig_out), 32'd0);

    // Debounce on ch0 with div 8: every 8-cycle block holds exactly one tick.
    step(1'b1, 1'b1, DIV_W'(8), '0, 1'b0, 1'b0);
    period(1'b1, 4'b0001, 24);
    check("deb_pre_rise", 32'(bus.sig_out[0]), 32'd0);
    step(1'b1, 1'b0, '0, 4'b0001, 1'b0, 1'b0);
    check("deb_rise", 32'(bus.sig_out[0]), 32'd1);
    period(1'b1, 4'b0000, 23);
    period(1'b1, 4'b0000, 8);
    check("deb_fall", 32'(bus.sig_out[0]), 32'd0);
    period(1'b1, 4'b0001, 8);
    period(1'b1, 4'b0001, 8);
    period(1'b1, 4'b0000, 8);
    period(1'b1, 4'b0001, 8);
    period(1'b1, 4'b0000, 8);
    check("deb_glitch", 32'(bus.sig_out[0]), 32'd0);

    // Timing at div 5, then overrun at div 2 and its clear by a later load.
    step(1'b1, 1'b1, DIV_W'(5), '0, 1'b0, 1'b0);
    rand_run(40, 100);
    step(1'b1, 1'b1, DIV_W'(2), '0, 1'b0, 1'b0);
    rand_run(12, 100);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    step(1'b1, 1'b1, DIV_W'(10), '0, 1'b0, 1'b0);
    rand_run(40, 100);
    check("ovr_clear", 32'(bus.overrun), 32'd0);

    // div_value 0 acts as 1; then enable drops in the second scan cycle.
    step(1'b1, 1'b1, DIV_W'(0), '0, 1'b0, 1'b0);
    rand_run(12, 100);
    step(1'b1, 1'b1, DIV_W'(7), '0, 1'b0, 1'b0);
    wait_busy();
    step(1'b1, 1'b0, '0, N_CH'($urandom), 1'b0, 1'b0);
    rand_run(20, 0);
    check("en_drop_idle", 32'(bus.busy), 32'd0);

    // Reset held two cycles in the middle of a round.
    step(1'b1, 1'b1, DIV_W'(6), '0, 1'b0, 1'b0);
    wait_busy();
    step(1'b1, 1'b0, '0, 4'hF, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 4'hF, 1'b0, 1'b1);
    check("mid_reset_out", 32'(bus.sig_out), 32'd0);
    check("mid_reset_busy", 32'(bus.busy), 32'd0);
    step(1'b1, 1'b1, DIV_W'(6), '0, 1'b0, 1'b0);
    period(1'b1, 4'b0100, 18);
    period(1'b1, 4'b0100, 6);
`ifdef FILTER_CHG_IRQ_EN
    check("irq_ch2", 32'(bus.irq), 32'd1);
`else
    check("irq_ch2", 32'(bus.irq), 32'd0);
`endif
    check("ch2_level", 32'(bus.sig_out), 32'h4);

    for (int s = 0; s < 8; s++) begin
      dv = (s == 3) ? DIV_W'($urandom_range(0, 3)) : DIV_W'($urandom_range(N_CH + 1, 12));
      if (s == 5)
        step(1'b1, 1'b0, '0, '1, 1'b0, 1'b1);
      step(1'b1, 1'b1, dv, N_CH'($urandom), 1'b0, 1'b0);
      rand_run(60, 90);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
